// File: rtl/rv32_pkg.sv
// Shared helpers for the rv32 pipeline: width calculations used by the elastic
// inter-stage buffers and by anything that needs to size their occupancy.
package rv32_pkg;

  localparam int PIPE_DEFAULT_DEPTH = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int pipe_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pipe_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_ptr.sv
// Modulo-DEPTH pointer for the elastic buffer; DEPTH need not be a power of two.
module pipe_elastic_ptr
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = pipe_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/pipe_elastic.sv
// Elastic, flushable valid/ready buffer between pipeline stages (circular, DEPTH entries).
// Optional PIPE_ELASTIC_PERF_EN adds the saturating backpressure_cycles counter port.
module pipe_elastic
  import rv32_pkg::*;
#(
  parameter type PTYPE = logic [31:0],
  parameter int  DEPTH = PIPE_DEFAULT_DEPTH,
  localparam int CNT_W = pipe_cnt_w(DEPTH),
  localparam int PTR_W = pipe_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  PTYPE             in_packet,
  output logic             out_valid,
  input  logic             out_ready,
  output PTYPE             out_packet,
  output logic [CNT_W-1:0] occupancy
`ifdef PIPE_ELASTIC_PERF_EN
  ,
  output logic [31:0]      backpressure_cycles
`endif
);

  PTYPE             mem [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Both handshake outputs come from count_reg only, so stalls never chain combinationally.
  assign in_ready   = (count_reg < CNT_W'(DEPTH));
  assign out_valid  = (count_reg != '0);
  assign out_packet = out_valid ? mem[rd_ptr] : '0;
  assign occupancy  = count_reg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Storage is deliberately not reset; stale entries are hidden by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_packet;
    end
  end

  pipe_elastic_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .inc  (pop),
    .ptr  (rd_ptr)
  );

  pipe_elastic_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .inc  (push),
    .ptr  (wr_ptr)
  );

`ifdef PIPE_ELASTIC_PERF_EN
  logic [31:0] bp_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_reg <= '0;
    end else if (in_valid && !in_ready && !flush && (bp_reg != 32'hFFFF_FFFF)) begin
      bp_reg <= bp_reg + 32'd1;
    end
  end

  assign backpressure_cycles = bp_reg;
`endif

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic: directed vector table on DEPTH=2, wrap sequence on DEPTH=3,
// and randomized traffic on both checked against a queue-based reference model.
module tb_pipe_elastic;
  import rv32_pkg::*;

  localparam int D0 = 2;
  localparam int D1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush      [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [31:0] in_packet  [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [31:0] out_packet [2];
  logic [pipe_cnt_w(D0)-1:0] occ0;
  logic [pipe_cnt_w(D1)-1:0] occ1;
`ifdef PIPE_ELASTIC_PERF_EN
  logic [31:0] bp [2];
`endif

  pipe_elastic #(.DEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_packet(in_packet[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_packet(out_packet[0]),
    .occupancy(occ0)
`ifdef PIPE_ELASTIC_PERF_EN
    , .backpressure_cycles(bp[0])
`endif
  );

  pipe_elastic #(.DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_packet(in_packet[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_packet(out_packet[1]),
    .occupancy(occ1)
`ifdef PIPE_ELASTIC_PERF_EN
    , .backpressure_cycles(bp[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one FIFO queue per DUT ----------------
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] bpm      [2];
  bit          accepted [2];
  bit          blocked  [2];

  function automatic int dep(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] mhead(input int k);
    if (msize(k) == 0) return 32'h0;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void mclear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic void mpush(input int k, input logic [31:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic void mpop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic logic [31:0] occ_of(input int k);
    return (k == 0) ? 32'(occ0) : 32'(occ1);
  endfunction

  // One clock: compare all outputs with the model mid-cycle, then advance the model at the edge.
  task automatic cycle_model();
    bit rdy;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_in_ready", k),   32'(in_ready[k]),  32'(msize(k) < dep(k)));
      chk($sformatf("d%0d_out_valid", k),  32'(out_valid[k]), 32'(msize(k) != 0));
      chk($sformatf("d%0d_out_packet", k), out_packet[k],     mhead(k));
      chk($sformatf("d%0d_occupancy", k),  occ_of(k),         32'(msize(k)));
`ifdef PIPE_ELASTIC_PERF_EN
      chk($sformatf("d%0d_backpressure", k), bp[k], bpm[k]);
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rdy = (msize(k) < dep(k));
      accepted[k] = in_valid[k] && rdy && !flush[k] && !reset;
      blocked[k]  = in_valid[k] && !rdy && !flush[k] && !reset;
      if (reset) bpm[k] = 32'h0;
      else if (in_valid[k] && !rdy && !flush[k]) bpm[k] = bpm[k] + 32'd1;
      if (reset || flush[k]) begin
        mclear(k);
      end else begin
        if (msize(k) != 0 && out_ready[k]) begin
          $display("dut%0d pop %h (occ %0d)", k, mhead(k), msize(k));
          mpop(k);
        end
        if (accepted[k]) mpush(k, in_packet[k]);
      end
    end
    #1;
  endtask

  task automatic idle_inputs(input int k);
    in_valid[k]  = 1'b0;
    in_packet[k] = 32'h0;
    out_ready[k] = 1'b0;
    flush[k]     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mclear(k);
      bpm[k]      = 32'h0;
      blocked[k]  = 1'b0;
      accepted[k] = 1'b0;
    end
  endtask

  // ---------------- directed vector table (DEPTH=2 instance) ----------------
  typedef struct {
    logic        iv;
    logic [31:0] pkt;
    logic        ordy;
    logic        fl;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_pkt;
    int          e_occ;
  } vec_t;

  vec_t vt [$];

  function automatic void add_vec(input logic iv, input logic [31:0] pkt, input logic ordy,
                                  input logic fl, input logic er, input logic ev,
                                  input logic [31:0] ep, input int eo);
    vec_t v;
    v.iv = iv; v.pkt = pkt; v.ordy = ordy; v.fl = fl;
    v.e_rdy = er; v.e_val = ev; v.e_pkt = ep; v.e_occ = eo;
    vt.push_back(v);
  endfunction

  task automatic run_table();
    for (int i = 0; i < vt.size(); i++) begin
      in_valid[0]  = vt[i].iv;
      in_packet[0] = vt[i].pkt;
      out_ready[0] = vt[i].ordy;
      flush[0]     = vt[i].fl;
      @(negedge clk);
      $display("vec %0d: iv=%b pkt=%h ordy=%b fl=%b -> rdy=%b val=%b out=%h occ=%0d",
               i, vt[i].iv, vt[i].pkt, vt[i].ordy, vt[i].fl,
               in_ready[0], out_valid[0], out_packet[0], occ0);
      chk($sformatf("vec%0d_in_ready", i),   32'(in_ready[0]),  32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i),  32'(out_valid[0]), 32'(vt[i].e_val));
      chk($sformatf("vec%0d_out_packet", i), out_packet[0],     vt[i].e_pkt);
      chk($sformatf("vec%0d_occupancy", i),  32'(occ0),         32'(vt[i].e_occ));
      @(posedge clk);
      #1;
    end
    idle_inputs(0);
  endtask

  task automatic rand_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        flush[k] = ($urandom_range(0, 29) == 0);
        // Producer rule: a refused packet is re-offered unchanged.
        if (!blocked[k]) begin
          in_valid[k]  = ($urandom_range(0, 3) != 0);
          in_packet[k] = $urandom;
        end
        out_ready[k] = (((c / 50) % 2) == 1) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
      end
      cycle_model();
    end
    reset = 1'b0;
  endtask

  int idx;

  initial begin
    reset = 1'b1;
    idle_inputs(0);
    idle_inputs(1);

    // Reset then idle: 5 cycles.
    for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 0, 1, 1'b0, 32'h0, 0);
    // Continuous stream 0x1..0x10, one-cycle latency.
    for (int i = 0; i < 18; i++) begin
      add_vec(i < 16, (i < 16) ? 32'(i + 1) : 32'h0, 1, 0, 1,
              (i >= 1 && i <= 16), (i >= 1 && i <= 16) ? 32'(i) : 32'h0,
              (i >= 1 && i <= 16) ? 1 : 0);
    end
    // Back-pressure: A, B accepted, C held until space frees.
    add_vec(1, 32'hA, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 32'hB, 0, 0, 1, 1, 32'hA, 1);
    add_vec(1, 32'hC, 0, 0, 0, 1, 32'hA, 2);
    add_vec(1, 32'hC, 1, 0, 0, 1, 32'hA, 2);
    add_vec(1, 32'hC, 1, 0, 1, 1, 32'hB, 1);
    add_vec(0, 32'h0, 1, 0, 1, 1, 32'hC, 1);
    add_vec(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
    // Flush with 0x5, 0x6 buffered and 0x7 offered; then flush kills an acceptable push.
    add_vec(1, 32'h5, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 32'h6, 0, 0, 1, 1, 32'h5, 1);
    add_vec(1, 32'h7, 0, 1, 0, 1, 32'h5, 2);
    add_vec(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
    add_vec(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
    add_vec(1, 32'h8, 0, 1, 1, 0, 32'h0, 0);
    add_vec(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);

    do_reset();
    run_table();

    // DEPTH=3 wrap: 7 pushes interleaved with sparse pops, then drain.
    do_reset();
    idx = 0;
    for (int i = 0; i < 24; i++) begin
      in_valid[1]  = (idx < 7);
      in_packet[1] = 32'h11 + 32'(idx);
      out_ready[1] = (i >= 14) || ((i % 3) == 2);
      cycle_model();
      if (accepted[1]) idx++;
    end
    chk("wrap_all_pushed", 32'(idx), 32'd7);
    chk("wrap_drained", 32'(occ1), 32'd0);
    idle_inputs(1);

`ifdef PIPE_ELASTIC_PERF_EN
    // Full buffer with in_valid held for 10 cycles, then flush, then reset.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid[0]  = 1'b1;
      in_packet[0] = (i < 2) ? 32'(i + 1) : 32'h3;
      cycle_model();
    end
    chk("bp_after_10", bp[0], 32'd10);
    flush[0] = 1'b1;
    cycle_model();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("bp_after_flush", bp[0], 32'd10);
    chk("flush_empties", 32'(out_valid[0]), 32'd0);
    reset = 1'b1;
    cycle_model();
    reset = 1'b0;
    chk("bp_after_reset", bp[0], 32'd0);
`endif

    do_reset();
    rand_phase(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
